// File: rtl/ei_axi4_pkg.sv
// Shared AXI4 types for the VIP master-side write arbiter.
package ei_axi4_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_type_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } response_e;

    // Write arbiter phases: one full AW/W/B transaction per grant.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2,
        ARB_RESP = 2'd3
    } arb_state_e;

endpackage

// File: rtl/ei_rr_picker.sv
// Combinational round-robin picker: first set request bit at or after rr_ptr.
module ei_rr_picker #(
    parameter  int NUM_REQ = 2,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     rr_ptr,
    output logic [IDW-1:0]     grant,
    output logic               valid
);

    // Walk offsets from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) begin
                grant = IDW'(idx);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ei_axi4_wr_arbiter.sv
// Round-robin arbiter sharing one AXI4 write path (AW, W, B) between NUM_REQ
// requesters, one whole transaction per grant, with wlast-vs-awlen checking.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module ei_axi4_wr_arbiter
    import ei_axi4_pkg::*;
#(
    parameter  int NUM_REQ        = 2,
    parameter  int DATA_WIDTH     = `DATA_WIDTH,
    parameter  int ADDR_WIDTH     = `ADDR_WIDTH,
    localparam int BUS_BYTE_LANES = DATA_WIDTH / 8,
    localparam int IDW            = $clog2(NUM_REQ)
) (
    input  logic                                aclk,
    input  logic                                areset,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]       req_awaddr,
    input  logic [NUM_REQ*8-1:0]                req_awlen,
    input  logic [NUM_REQ*3-1:0]                req_awsize,
    input  logic [NUM_REQ*2-1:0]                req_awburst,
    input  logic [NUM_REQ-1:0]                  req_awvalid,
    output logic [NUM_REQ-1:0]                  req_awready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_wdata,
    input  logic [NUM_REQ*BUS_BYTE_LANES-1:0]   req_wstrb,
    input  logic [NUM_REQ-1:0]                  req_wlast,
    input  logic [NUM_REQ-1:0]                  req_wvalid,
    output logic [NUM_REQ-1:0]                  req_wready,
    output response_e                           req_bresp,
    output logic [NUM_REQ-1:0]                  req_bvalid,
    input  logic [NUM_REQ-1:0]                  req_bready,
    output logic [ADDR_WIDTH-1:0]               m_awaddr,
    output logic [7:0]                          m_awlen,
    output logic [2:0]                          m_awsize,
    output logic [1:0]                          m_awburst,
    output logic                                m_awvalid,
    input  logic                                m_awready,
    output logic [DATA_WIDTH-1:0]               m_wdata,
    output logic [BUS_BYTE_LANES-1:0]           m_wstrb,
    output logic                                m_wlast,
    output logic                                m_wvalid,
    input  logic                                m_wready,
    input  logic [1:0]                          m_bresp,
    input  logic                                m_bvalid,
    output logic                                m_bready,
    output logic [IDW-1:0]                      grant_id,
    output logic                                busy,
    output logic                                err_wlast
);

    arb_state_e     state, state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] pick;
    logic           pick_vld;
    logic [7:0]     len_q;
    logic [7:0]     beat_cnt;
    logic           last_beat;
    logic           aw_hs, w_hs, b_hs;

    ei_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req    (req_awvalid),
        .rr_ptr (rr_ptr),
        .grant  (pick),
        .valid  (pick_vld)
    );

    // The master generates wlast itself; the requester's wlast is only checked.
    assign last_beat = (beat_cnt == len_q);
    assign busy      = (state != ARB_IDLE);
    assign req_bresp = response_e'(m_bresp);

    // Next state plus routing of the granted slot; everything else held at 0.
    always_comb begin
        state_nxt   = state;
        m_awaddr    = req_awaddr[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
        m_awlen     = req_awlen[grant_id*8 +: 8];
        m_awsize    = req_awsize[grant_id*3 +: 3];
        m_awburst   = req_awburst[grant_id*2 +: 2];
        m_wdata     = req_wdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
        m_wstrb     = req_wstrb[grant_id*BUS_BYTE_LANES +: BUS_BYTE_LANES];
        m_awvalid   = 1'b0;
        m_wvalid    = 1'b0;
        m_wlast     = 1'b0;
        m_bready    = 1'b0;
        req_awready = '0;
        req_wready  = '0;
        req_bvalid  = '0;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        b_hs        = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_vld) state_nxt = ARB_ADDR;
            end
            ARB_ADDR: begin
                m_awvalid             = req_awvalid[grant_id];
                req_awready[grant_id] = m_awready;
                aw_hs                 = req_awvalid[grant_id] & m_awready;
                if (aw_hs) state_nxt = ARB_DATA;
            end
            ARB_DATA: begin
                m_wvalid             = req_wvalid[grant_id];
                m_wlast              = last_beat;
                req_wready[grant_id] = m_wready;
                w_hs                 = req_wvalid[grant_id] & m_wready;
                if (w_hs && last_beat) state_nxt = ARB_RESP;
            end
            ARB_RESP: begin
                m_bready             = req_bready[grant_id];
                req_bvalid[grant_id] = m_bvalid;
                b_hs                 = m_bvalid & req_bready[grant_id];
                if (b_hs) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) state <= ARB_IDLE;
        else        state <= state_nxt;
    end

    // Grant, round-robin pointer, beat counting and the wlast error pulse.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rr_ptr    <= '0;
            grant_id  <= '0;
            len_q     <= '0;
            beat_cnt  <= '0;
            err_wlast <= 1'b0;
        end else begin
            err_wlast <= w_hs & (req_wlast[grant_id] != last_beat);
            if (state == ARB_IDLE && pick_vld) grant_id <= pick;
            if (aw_hs) begin
                len_q    <= req_awlen[grant_id*8 +: 8];
                beat_cnt <= '0;
            end
            // Hold at len_q on the final beat so the counter never wraps.
            if (w_hs && !last_beat) beat_cnt <= beat_cnt + 8'd1;
            if (b_hs) rr_ptr <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: doc/ei_axi4_wr_arbiter.md
# ei_axi4_wr_arbiter

Round-robin arbiter that shares one AXI4 master write path (AW, W and B channels) between NUM_REQ requesters inside the VIP's master-side RTL model. A requester is granted on its AW request and keeps the write path for the whole transaction: address, all data beats, then the write response. At most one write transaction is outstanding at a time. The block also checks that each requester's wlast position matches its awlen.

## Interface
Parameters:
- NUM_REQ, 2: requester count, legal 2..4.
- DATA_WIDTH, `DATA_WIDTH: write data width; BUS_BYTE_LANES = DATA_WIDTH/8.
- ADDR_WIDTH, `ADDR_WIDTH: address width.

Ports:
- Clocking and reset: one clock, aclk; reset areset is synchronous and active-high.
- aclk  in  1  clock.
- areset  in  1  synchronous, active-high reset.
- req_awaddr  in  NUM_REQ*ADDR_WIDTH  packed per-requester AW address; slot i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_awlen/req_awsize/req_awburst  in  NUM_REQ*8 / NUM_REQ*3 / NUM_REQ*2  packed AW attributes.
- req_awvalid  in  NUM_REQ  per-requester AW valid.
- req_awready  out  NUM_REQ  per-requester AW ready.
- req_wdata/req_wstrb  in  NUM_REQ*DATA_WIDTH / NUM_REQ*BUS_BYTE_LANES  packed W payload.
- req_wlast/req_wvalid  in  NUM_REQ each  W last and valid.
- req_wready  out  NUM_REQ  W ready.
- req_bresp  out  2  response_e; broadcast to all requesters.
- req_bvalid  out  NUM_REQ  B valid, granted slot only.
- req_bready  in  NUM_REQ  B ready.
- m_awaddr/m_awlen/m_awsize/m_awburst/m_awvalid  out  ADDR_WIDTH/8/3/2/1  master AW.
- m_awready  in  1.
- m_wdata/m_wstrb/m_wlast/m_wvalid  out  DATA_WIDTH/BUS_BYTE_LANES/1/1  master W.
- m_wready  in  1.
- m_bresp  in  2.
- m_bvalid  in  1.
- m_bready  out  1.
- grant_id  out  $clog2(NUM_REQ)  currently granted requester.
- busy  out  1  high in any state except IDLE.
- err_wlast  out  1  one-cycle error pulse.

## Operation
State machine: IDLE → ADDR → DATA → RESP → IDLE.
- **IDLE**
  - Scan req_awvalid in round-robin order, starting at rr_ptr.
  - Register the first set bit into grant_id, then go to ADDR.
  - Stay in IDLE if no bit is set.
- **ADDR**
  - Mux the granted slot's AW fields and valid onto m_aw*.
  - req_awready[grant_id] = m_awready; all other requesters' awready = 0.
  - On m_awvalid & m_awready: latch awlen into len_q, clear beat_cnt, go to DATA.
- **DATA**
  - Mux the granted slot's W channel onto m_w*; req_wready[grant_id] = m_wready.
  - m_wlast is generated internally as (beat_cnt == len_q); the requester's wlast is not forwarded.
  - On each W handshake, increment beat_cnt.
  - On the handshake where beat_cnt == len_q, go to RESP.
  - err_wlast pulses on any W handshake where req_wlast[grant_id] != (beat_cnt == len_q).
  - A wlast error does not abort the burst; the transfer always completes awlen+1 beats.
- **RESP**
  - m_bready = req_bready[grant_id]; req_bvalid[grant_id] = m_bvalid.
  - On the B handshake: rr_ptr = (grant_id+1) mod NUM_REQ, go to IDLE.
- Outside the owning state, every master-side valid/ready and every requester-side ready/valid is 0.
- Non-granted requesters always see ready=0 and bvalid=0.
- Widths:
  - beat_cnt is 8 bits and never wraps, because awlen ≤ 255 gives at most 256 beats.
  - rr_ptr wraps modulo NUM_REQ, including non-power-of-two NUM_REQ=3.

## Timing
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, busy=0, err_wlast=0, beat_cnt=0, len_q=0.
- Because reset holds state at IDLE, all valid/ready outputs are 0 during reset.
- Reset asserted mid-transaction returns to IDLE on the next edge. No drain; no response is generated.
- Latency:
  - req_awvalid rises in cycle N (IDLE) → m_awvalid high in cycle N+1.
  - The AW handshake edge moves to DATA; W can pass from the next cycle.
  - The last W handshake moves to RESP; B can pass from the next cycle.
  - IDLE lasts exactly 1 cycle between back-to-back transactions.
- W and B paths are combinational pass-through; there are no data registers.
- Simultaneous requests in IDLE: round-robin from rr_ptr decides the winner.
- Requests that arrive while busy wait; their AWVALID must stay asserted per AXI.
- W data offered by a requester before the DATA state is not accepted, because wready=0.

## Structure
- burst_type_e, response_e and the arbiter state enum (IDLE/ADDR/DATA/RESP) belong in the shared package ei_axi4_pkg.
- Sub-module ei_rr_picker: combinational round-robin first-set-bit finder over (req vector, rr_ptr), with a `grant` output.

## Test plan
- Single requester 0, awlen=3: 4 beats pass; m_wlast is set only on beat 4; B OKAY is returned to slot 0; grant_id=0; busy falls after B.
- Both requesters raise awvalid in the same cycle after reset: slot 0 is granted first, then slot 1; a third concurrent round goes to slot 0.
- m_wready toggled 1/0 during an 8-beat burst: exactly 8 beats transfer; no beat is lost or duplicated.
- Requester asserts wlast on beat 2 of awlen=3: err_wlast pulses once at beat 2; the burst still completes 4 beats.
- areset asserted during DATA: next cycle all valid/ready outputs are 0, state=IDLE, rr_ptr=0; a following transaction completes normally.
- NUM_REQ=3, all three requesting continuously: grant order is 0,1,2,0,...
